instr_mem_loader: RTL and testbench

- Instruction-side responder for the pipelined datapath: serves 32-bit instructions addressed by the fetch-stage PC.
- Owns the program store and fills it from a byte-stream debug link using a valid/ready handshake.
- Holds the CPU in reset while loading; releases it once the program is complete.
- Sits between the debug/UART receiver and the datapath's `instruction` input and fetch-stage PC output.

---
 rtl/instr_mem_loader.sv | 118 +++++++++++
 tb/tb_instr_mem_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction-side program store: byte-stream loader with valid/ready handshake
// and a zero-latency read port, gated by the number of words loaded.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter logic [31:0] END_MARKER = 32'hFFFFFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  loadStart,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           instruction,
  output logic                  cpuReset,
  output logic                  loadDone,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] wcnt_q, wcnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         asm_q, asm_d;
  logic                ovf_q, ovf_d;
  logic                we;
  logic                accept;
  logic [31:0]         word;
  logic [31:0]         mem_q [DEPTH];

  assign byteReady = (state_q == LOAD) && !loadStart;
  assign accept    = byteValid && byteReady;
  assign word      = {asm_q, byteIn};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (loadStart) begin
          state_d = LOAD;
          wcnt_d  = '0;
          idx_d   = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (loadStart) begin
          wcnt_d = '0;
          idx_d  = '0;
          asm_d  = '0;
        end else if (accept) begin
          if (idx_q == 2'd3) begin
            idx_d = '0;
            asm_d = '0;
            if (word == END_MARKER) begin
              state_d = RUN;
            end else if (wcnt_q < DEPTH_W) begin
              we     = 1'b1;
              wcnt_d = wcnt_q + ONE_W;
            end else begin
              ovf_d   = 1'b1;
              state_d = RUN;
            end
          end else begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    asm_d[23:16] = byteIn;
              2'd1:    asm_d[15:8]  = byteIn;
              default: asm_d[7:0]   = byteIn;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Store is never cleared; wordCount masks stale contents on the read side.
  always_ff @(posedge clock) begin
    if (we) mem_q[wcnt_q[IW-1:0]] <= word;
  end

  assign instruction = ({1'b0, pc} < wcnt_q) ? mem_q[pc[IW-1:0]] : 32'h0000_0000;
  assign cpuReset    = (state_q != RUN);
  assign loadDone    = (state_q == RUN);
  assign overflow    = ovf_q;
  assign wordCount   = wcnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a DEPTH=256 and a DEPTH=4 instance, checked against a
// word-level model of the load rules.
module tb_instr_mem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tb_start = 1'b0;
  logic        tb_valid = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  byteIn = 8'h00;
  logic [7:0]  pc = 8'h00;

  logic        start_a, start_b, valid_a, valid_b;
  logic        rdy_a, rdy_b, cr_a, cr_b, ld_a, ld_b, ov_a, ov_b;
  logic [31:0] ins_a, ins_b;
  logic [8:0]  wc_a, wc_b;

  logic        obs_ready, obs_cr, obs_ld, obs_ov;
  logic [31:0] obs_ins;
  logic [8:0]  obs_wc;

  int assertions = 0;
  int failures = 0;

  bit          m_loading, m_run, m_ovf;
  int          m_wc;
  logic [31:0] m_mem [256];
  logic [7:0]  m_part [$];

  assign start_a = sel ? 1'b0 : tb_start;
  assign start_b = sel ? tb_start : 1'b0;
  assign valid_a = sel ? 1'b0 : tb_valid;
  assign valid_b = sel ? tb_valid : 1'b0;

  assign obs_ready = sel ? rdy_b : rdy_a;
  assign obs_cr    = sel ? cr_b : cr_a;
  assign obs_ld    = sel ? ld_b : ld_a;
  assign obs_ov    = sel ? ov_b : ov_a;
  assign obs_ins   = sel ? ins_b : ins_a;
  assign obs_wc    = sel ? wc_b : wc_a;

  instr_mem_loader #(.ADDR_WIDTH(8), .DEPTH(256), .END_MARKER(32'hFFFFFFFF)) dut_a (
    .clock(clock), .reset(reset), .loadStart(start_a), .byteIn(byteIn),
    .byteValid(valid_a), .byteReady(rdy_a), .pc(pc), .instruction(ins_a),
    .cpuReset(cr_a), .loadDone(ld_a), .overflow(ov_a), .wordCount(wc_a)
  );

  instr_mem_loader #(.ADDR_WIDTH(8), .DEPTH(4), .END_MARKER(32'hFFFFFFFF)) dut_b (
    .clock(clock), .reset(reset), .loadStart(start_b), .byteIn(byteIn),
    .byteValid(valid_b), .byteReady(rdy_b), .pc(pc), .instruction(ins_b),
    .cpuReset(cr_b), .loadDone(ld_b), .overflow(ov_b), .wordCount(wc_b)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------- reference model (word-level) ----------------
  function automatic int m_depth();
    return sel ? 4 : 256;
  endfunction

  task automatic model_reset();
    m_loading = 0; m_run = 0; m_ovf = 0; m_wc = 0; m_part.delete();
  endtask

  task automatic model_start();
    m_loading = 1; m_run = 0; m_ovf = 0; m_wc = 0; m_part.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_loading) return;
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      w = {m_part[0], m_part[1], m_part[2], m_part[3]};
      m_part.delete();
      if (w == 32'hFFFFFFFF) begin
        m_loading = 0; m_run = 1;
      end else if (m_wc < m_depth()) begin
        m_mem[m_wc] = w; m_wc++;
      end else begin
        m_ovf = 1; m_loading = 0; m_run = 1;
      end
    end
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      tb_valid = 1'b0; byteIn = 8'($urandom);
      @(posedge clock); #1;
    end
    tb_valid = 1'b1; byteIn = b;
    #1;
    assertions++;
    if (obs_ready !== m_loading) begin
      failures++;
      $display("FAIL byteReady: got %b want %b", obs_ready, m_loading);
    end
    @(posedge clock);
    model_byte(b);
    #1;
    tb_valid = 1'b0;
    assertions++;
    if (obs_ld !== m_run || obs_cr !== !m_run) begin
      failures++;
      $display("FAIL run_flags: loadDone %b cpuReset %b want %b %b", obs_ld, obs_cr, m_run, !m_run);
    end
    assertions++;
    if (obs_wc !== 9'(m_wc) || obs_ov !== m_ovf) begin
      failures++;
      $display("FAIL count: wordCount %0d overflow %b want %0d %b", obs_wc, obs_ov, m_wc, m_ovf);
    end
  endtask

  task automatic pulse_start(input logic valid, input logic [7:0] b);
    tb_start = 1'b1; tb_valid = valid; byteIn = b;
    #1;
    assertions++;
    if (obs_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_during_start: got %b want 0", obs_ready);
    end
    @(posedge clock);
    model_start();
    #1;
    tb_start = 1'b0; tb_valid = 1'b0;
    #1;
    assertions++;
    if (obs_ready !== 1'b1 || obs_cr !== 1'b1 || obs_ld !== 1'b0 || obs_wc !== 9'd0) begin
      failures++;
      $display("FAIL load_entry: ready %b cpuReset %b loadDone %b wc %0d want 1 1 0 0",
               obs_ready, obs_cr, obs_ld, obs_wc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    assertions++;
    if (obs_cr !== 1'b1 || obs_ready !== 1'b0 || obs_ld !== 1'b0 ||
        obs_wc !== 9'd0 || obs_ov !== 1'b0 || obs_ins !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: cr %b rdy %b ld %b wc %0d ov %b ins %h want 1 0 0 0 0 0",
               obs_cr, obs_ready, obs_ld, obs_wc, obs_ov, obs_ins);
    end
    model_reset();
    @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic check_reads();
    logic [31:0] exp;
    int p;
    for (int i = 0; i < m_wc + 5; i++) begin
      p = (i < m_wc + 2) ? i : int'($urandom_range(255));
      pc = 8'(p);
      #1;
      exp = (p < m_wc) ? m_mem[p] : 32'h0;
      assertions++;
      if (obs_ins !== exp) begin
        failures++;
        $display("FAIL read pc=%0d: got %h want %h", p, obs_ins, exp);
      end
    end
  endtask

  task automatic send_words(input logic [31:0] words [$], input int mode);
    logic [31:0] w;
    int gap;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 3; k >= 0; k--) begin
        gap = (mode == 0) ? 0 : (mode == 1) ? ((i == 0 && k == 3) ? 0 : 1)
                                            : int'($urandom_range(2));
        send_byte(w[k*8 +: 8], gap);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    assertions++;
    if (obs_cr !== 1'b1 || obs_ld !== 1'b0 || obs_ready !== 1'b0 ||
        obs_ins !== 32'h0 || obs_wc !== 9'd0 || obs_ov !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: cr %b ld %b rdy %b ins %h wc %0d ov %b",
               obs_cr, obs_ld, obs_ready, obs_ins, obs_wc, obs_ov);
    end
    model_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    send_byte(8'h5A, 0);
  endtask

  task automatic load_basic(input int mode);
    logic [31:0] s [$];
    s = '{32'h00000020, 32'h8C010004, 32'hFFFFFFFF};
    pulse_start(1'b0, 8'h00);
    send_words(s, mode);
    assertions++;
    if (obs_wc !== 9'd2 || obs_ld !== 1'b1 || obs_cr !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: wc %0d ld %b cr %b want 2 1 0", obs_wc, obs_ld, obs_cr);
    end
    pc = 8'd0; #1;
    assertions++;
    if (obs_ins !== 32'h00000020) begin
      failures++; $display("FAIL basic_pc0: got %h want 00000020", obs_ins);
    end
    pc = 8'd1; #1;
    assertions++;
    if (obs_ins !== 32'h8C010004) begin
      failures++; $display("FAIL basic_pc1: got %h want 8c010004", obs_ins);
    end
    pc = 8'd2; #1;
    assertions++;
    if (obs_ins !== 32'h0) begin
      failures++; $display("FAIL basic_pc2: got %h want 00000000", obs_ins);
    end
    check_reads();
  endtask

  task automatic test_basic_load();
    sel = 1'b0;
    load_basic(0);
    send_byte(8'h11, 0);
  endtask

  task automatic test_toggle_valid();
    load_basic(1);
  endtask

  task automatic test_restart();
    logic [31:0] s [$];
    pulse_start(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    pulse_start(1'b1, 8'h77);
    s = '{32'hAABBCCDD, 32'hFFFFFFFF};
    send_words(s, 0);
    pc = 8'd0; #1;
    assertions++;
    if (obs_wc !== 9'd1 || obs_ins !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL restart: wc %0d mem0 %h want 1 aabbccdd", obs_wc, obs_ins);
    end
    check_reads();
  endtask

  task automatic test_overflow();
    logic [31:0] s [$];
    logic [31:0] w;
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      if (w == 32'hFFFFFFFF) w = 32'h12345678;
      s.push_back(w);
    end
    pulse_start(1'b0, 8'h00);
    send_words(s, 0);
    pc = 8'd3; #1;
    assertions++;
    if (obs_ov !== 1'b1 || obs_ld !== 1'b1 || obs_wc !== 9'd4 || obs_ins !== s[3]) begin
      failures++;
      $display("FAIL overflow: ov %b ld %b wc %0d pc3 %h want 1 1 4 %h",
               obs_ov, obs_ld, obs_wc, obs_ins, s[3]);
    end
    check_reads();
    send_byte(8'hFF, 0);
    sel = 1'b0;
    do_reset();
  endtask

  task automatic test_async_reset();
    pulse_start(1'b0, 8'h00);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    do_reset();
    check_reads();
    load_basic(0);
  endtask

  task automatic test_run_reload();
    logic [31:0] s [$];
    pulse_start(1'b0, 8'h00);
    pc = 8'd0; #1;
    assertions++;
    if (obs_ins !== 32'h0) begin
      failures++; $display("FAIL reload_mask: pc0 got %h want 00000000", obs_ins);
    end
    check_reads();
    s = '{32'hCAFEF00D, 32'hFFFFFFFF};
    send_words(s, 2);
    check_reads();
  endtask

  task automatic test_random();
    logic [31:0] s [$];
    logic [31:0] w;
    int n;
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom);
      do_reset();
      s.delete();
      n = $urandom_range(6);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == 32'hFFFFFFFF) w = 32'h0;
        s.push_back(w);
      end
      s.push_back(32'hFFFFFFFF);
      pulse_start(1'b0, 8'h00);
      send_words(s, 2);
      check_reads();
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_toggle_valid();
    test_restart();
    test_overflow();
    test_async_reset();
    test_run_reload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
